// File: rtl/demux4_stream_pkg.sv
// Shared types and helpers for the 1-to-4 stream demultiplexer.
package demux_pkg;

    localparam int NUM_CH = 4;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} buf_state_t;

    function automatic logic [NUM_CH-1:0] onehot(input logic [1:0] sel);
        onehot      = '0;
        onehot[sel] = 1'b1;
    endfunction

endpackage

// File: rtl/demux4_stream_fifo2.sv
// Two-entry valid/ready FIFO of {data, sel}; slot 0 is always the head entry.
module stream_fifo2
    import demux_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic [1:0]       push_sel_i,
    output logic             push_ready_o,
    input  logic             pop_i,
    output logic             head_valid_o,
    output logic [WIDTH-1:0] head_data_o,
    output logic [1:0]       head_sel_o
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [1:0]       sel;
    } entry_t;

    buf_state_t state_q, state_d;
    entry_t     slot0_q, slot0_d;
    entry_t     slot1_q, slot1_d;
    entry_t     new_e;
    logic       ready_q, ready_d;
    logic       enq, deq;

    assign new_e = '{data: push_data_i, sel: push_sel_i};
    assign enq   = push_i && ready_q;
    assign deq   = pop_i && (state_q != EMPTY);

    // ready_q is the registered image of (state != FULL); it resets low so the
    // producer sees no readiness while reset is asserted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
            slot0_q <= '0;
            slot1_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        case (state_q)
            EMPTY: begin
                if (enq) begin
                    state_d = ONE;
                    slot0_d = new_e;
                end
            end
            ONE: begin
                if (enq && deq) begin
                    slot0_d = new_e;
                end else if (enq) begin
                    state_d = FULL;
                    slot1_d = new_e;
                end else if (deq) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (deq) begin
                    state_d = ONE;
                    slot0_d = slot1_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        ready_d = (state_d != FULL);
    end

    assign push_ready_o = ready_q;
    assign head_valid_o = (state_q != EMPTY);
    assign head_data_o  = slot0_q.data;
    assign head_sel_o   = slot0_q.sel;

endmodule

// File: rtl/demux4_stream.sv
// Registered 1-to-4 stream demultiplexer: each accepted word goes to the
// channel named by its SEL, in strict acceptance order.
module demux4_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [1:0]        SEL,
    input  logic [WIDTH-1:0]  DIN,
    input  logic              IN_VALID,
    output logic              IN_READY,
    output logic [WIDTH-1:0]  DOUT,
    output logic [NUM_CH-1:0] OUT_VALID,
    input  logic [NUM_CH-1:0] OUT_READY
);

    logic             head_valid;
    logic [WIDTH-1:0] head_data;
    logic [1:0]       head_sel;
    logic             pop;

    stream_fifo2 #(.WIDTH(WIDTH)) u_fifo (
        .clk_i        (CLK),
        .rst_ni       (RST_N),
        .push_i       (IN_VALID),
        .push_data_i  (DIN),
        .push_sel_i   (SEL),
        .push_ready_o (IN_READY),
        .pop_i        (pop),
        .head_valid_o (head_valid),
        .head_data_o  (head_data),
        .head_sel_o   (head_sel)
    );

    // Only the head's own consumer can retire it; other ready bits are ignored.
    assign pop       = head_valid && OUT_READY[head_sel];
    assign OUT_VALID = head_valid ? onehot(head_sel) : '0;
    assign DOUT      = head_valid ? head_data : '0;

endmodule
